sample_buffer_writer: RTL and testbench
=======================================

Name: sample_buffer_writer

Overview:
- Captures 12-bit audio samples on each `sample_tick` and writes them into one half of an external ping-pong pair of 2048×12 buffers.
- When a half fills, it hands that half to the f0 estimator by swapping the write target and pulsing `start_round`.
- Sits between the ADC/sample register (with its tick source, `clock_divider`) and the two block RAMs read by `f0_estimation`.

Parameters:
- DATA_W, 12, sample width.
- ADDR_W, 11, buffer address width.
- DEPTH, 2048, samples per buffer half (must equal 2**ADDR_W).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- f0_done  in  1  one-cycle pulse: estimator finished the round it was given.
- current_data  in  DATA_W  sample value, valid when sample_tick=1.
- sample_tick  in  1  one-cycle sample strobe; ticks are always ≥2 clk apart.
- start_round  out  1  one-cycle pulse: the buffer just released is full; estimator may start.
- addr  out  ADDR_W  write address for the buffer selected by en.
- current_sample  out  DATA_W  write data, registered.
- now_writing  out  1  1 while samples are accepted; 0 in WAIT.
- en  out  2  one-hot write select: en[0]=buffer0, en[1]=buffer1. The other buffer is the read side; the read mux selects buffer0 when en[0]=0.

Behaviour:
- Reset values:
  - addr=0, current_sample=0, en=2'b01, now_writing=1, start_round=0.
  - Internal count=0, busy=0.
- Write model: RAM writes at (addr, current_sample) every clk while en bit is high. Repeated writes of held data are harmless by design, so addr and current_sample change only as defined below.
- FILL state (now_writing=1): on sample_tick, in the same clock edge:
  - current_sample<=current_data;
  - addr<=count;
  - count<=count+1.
  - Registered data lands in RAM one cycle after the tick.
- Full condition: the tick storing index DEPTH-1. On the following cycle, go to SWAP.
- SWAP (single-cycle decision):
  - If busy=0, or f0_done=1 this cycle: toggle en (01↔10), count<=0, addr<=0, pulse start_round=1 for exactly one cycle, set busy=1, return to FILL. A tick arriving this cycle is taken as index 0 of the new buffer.
  - Otherwise go to WAIT.
- WAIT:
  - now_writing=0; en, addr (=DEPTH-1) and current_sample are held; sample_ticks are dropped.
  - On f0_done, perform the SWAP actions above in the same cycle and return to FILL.
- Stale write: after a swap, the new buffer's address 0 briefly receives the old last sample until the first new tick overwrites it. This is accepted.
- busy flag:
  - Set on start_round; cleared on f0_done.
  - f0_done while busy=0 is ignored.
  - f0_done and the swap in the same cycle count as idle, so the swap proceeds.
- count is ADDR_W+1 bits wide; it must never write beyond DEPTH-1 (no address wrap within a buffer).
- start_round never asserts in consecutive cycles, and never asserts while busy=1 without f0_done in the same cycle.
- Reset mid-fill or mid-WAIT returns all outputs to reset values on the next edge. Partially filled data is abandoned.

Decomposition:
- Shared package: DATA_W, ADDR_W, DEPTH, and the state enum {FILL, SWAP, WAIT}.
- No sub-module is needed; a single FSM with counter.
- The tick source (clock_divider) and reset conditioning (button) remain separate blocks, instantiated beside this one.

Test Plan:
- Reset, no ticks → en=01, addr=0, current_sample=0, now_writing=1, start_round stays 0 for 100 cycles.
- 2048 ticks every 16 clk with data=index:
  - addr follows 0..2047 and current_sample=index;
  - exactly one start_round pulse, the cycle after tick 2047;
  - en=10 and addr=0 thereafter.
- Continue 2048 more ticks with no f0_done → WAIT: now_writing=0, en=10, addr=2047 held; extra ticks do not change current_sample.
- Then pulse f0_done → same cycle: en=01, addr=0, start_round pulse, now_writing=1; next tick writes index 0 into buffer0.
- f0_done during FILL (after the first round) → at the next full condition, swap is immediate with no WAIT. f0_done before any round → ignored.
- Assert rst after 1000 ticks → next edge: en=01, addr=0, count restarts; full round of 2048 ticks needed before start_round.

Source files
------------

// File: rtl/sample_buffer_writer_pkg.sv
// sample_buffer_writer_pkg
//   Shared constants and types for the ping-pong sample buffer writer.
//   DATA_W  : sample width
//   ADDR_W  : buffer address width
//   DEPTH   : samples per buffer half, always 2**ADDR_W
//   state_t : writer FSM states (FILL, SWAP, WAIT)
package sample_buffer_writer_pkg;

  localparam int unsigned DATA_W  = 12;
  localparam int unsigned ADDR_W  = 11;
  localparam int unsigned DEPTH   = 2048;
  // One extra bit so the counter can hold DEPTH without aliasing to index 0.
  localparam int unsigned COUNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    SWAP = 2'd1,
    WAIT = 2'd2
  } state_t;

  localparam logic [1:0] EN_BUF0 = 2'b01;
  localparam logic [1:0] EN_BUF1 = 2'b10;

  // Returns the one-hot select of the opposite buffer half.
  function automatic logic [1:0] swap_en(input logic [1:0] en);
    if (en == EN_BUF1) begin
      return EN_BUF0;
    end else begin
      return EN_BUF1;
    end
  endfunction

endpackage

// File: rtl/sample_buffer_writer_if.sv
// sample_buffer_writer_if
//   Bundle between the buffer writer and its neighbours (sample source,
//   ping-pong RAMs, f0 estimator).
//   master : the writer (drives start_round, addr, current_sample,
//            now_writing, en; receives f0_done, current_data, sample_tick)
//   slave  : the surrounding blocks, opposite directions
interface sample_buffer_writer_if;
  import sample_buffer_writer_pkg::*;

  logic              f0_done;
  logic [DATA_W-1:0] current_data;
  logic              sample_tick;
  logic              start_round;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] current_sample;
  logic              now_writing;
  logic [1:0]        en;

  modport master (
    input  f0_done,
    input  current_data,
    input  sample_tick,
    output start_round,
    output addr,
    output current_sample,
    output now_writing,
    output en
  );

  modport slave (
    output f0_done,
    output current_data,
    output sample_tick,
    input  start_round,
    input  addr,
    input  current_sample,
    input  now_writing,
    input  en
  );

endinterface

// File: rtl/sample_buffer_writer.sv
// sample_buffer_writer
//   Captures one sample per sample_tick into the write half of a ping-pong
//   buffer pair. When a half holds DEPTH samples it is released to the f0
//   estimator (en toggles, start_round pulses). If the estimator still owns
//   the other half, the writer parks in WAIT, dropping ticks, until f0_done.
//   Ports:
//     clk : system clock
//     rst : synchronous active-high reset
//     bus : sample_buffer_writer_if.master (f0_done, current_data,
//           sample_tick in; start_round, addr, current_sample,
//           now_writing, en out -- all outputs registered)
module sample_buffer_writer
  import sample_buffer_writer_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  sample_buffer_writer_if.master       bus
);

  localparam logic [COUNT_W-1:0] LAST_IDX  = COUNT_W'(DEPTH - 1);
  localparam logic [COUNT_W-1:0] COUNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t              state_r;
  logic [COUNT_W-1:0]  count_r;
  logic                busy_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [DATA_W-1:0]   current_sample_r;
  logic [1:0]          en_r;
  logic                now_writing_r;
  logic                start_round_r;
  logic                swap_s;

  assign bus.addr           = addr_r;
  assign bus.current_sample = current_sample_r;
  assign bus.en             = en_r;
  assign bus.now_writing    = now_writing_r;
  assign bus.start_round    = start_round_r;

  // Swap decision: the estimator is free, or finishing in this very cycle.
  always_comb begin
    swap_s = 1'b0;
    case (state_r)
      SWAP:    swap_s = (~busy_r) | bus.f0_done;
      WAIT:    swap_s = bus.f0_done;
      default: swap_s = 1'b0;
    endcase
  end

  // Writer FSM, sample counter, estimator-busy flag and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r          <= FILL;
      count_r          <= {COUNT_W{1'b0}};
      busy_r           <= 1'b0;
      addr_r           <= {ADDR_W{1'b0}};
      current_sample_r <= {DATA_W{1'b0}};
      en_r             <= EN_BUF0;
      now_writing_r    <= 1'b1;
      start_round_r    <= 1'b0;
    end else begin
      start_round_r <= 1'b0;

      // A swap re-arms busy even when f0_done lands in the same cycle.
      if (swap_s) begin
        busy_r <= 1'b1;
      end else if (bus.f0_done) begin
        busy_r <= 1'b0;
      end else begin
        busy_r <= busy_r;
      end

      case (state_r)
        FILL: begin
          if (bus.sample_tick) begin
            current_sample_r <= bus.current_data;
            addr_r           <= count_r[ADDR_W-1:0];
            count_r          <= count_r + COUNT_ONE;
            if (count_r == LAST_IDX) begin
              state_r <= SWAP;
            end else begin
              state_r <= FILL;
            end
          end else begin
            state_r <= FILL;
          end
        end

        SWAP, WAIT: begin
          if (swap_s) begin
            en_r          <= swap_en(en_r);
            start_round_r <= 1'b1;
            now_writing_r <= 1'b1;
            addr_r        <= {ADDR_W{1'b0}};
            state_r       <= FILL;
            // A coincident tick becomes sample 0 of the new half.
            if (bus.sample_tick) begin
              current_sample_r <= bus.current_data;
              count_r          <= COUNT_ONE;
            end else begin
              count_r          <= {COUNT_W{1'b0}};
            end
          end else begin
            // addr stays at DEPTH-1 and data is held; ticks are dropped.
            now_writing_r <= 1'b0;
            state_r       <= WAIT;
          end
        end

        default: begin
          state_r <= FILL;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sample_buffer_writer.sv
// tb_sample_buffer_writer
//   Drives random samples with random tick spacing and checks the writer
//   against a round-level model: which samples belong to the current half,
//   who owns the read half, and what each released half must contain.
module tb_sample_buffer_writer;

  localparam int DEPTH_TB = 2048;

  logic clk;
  logic rst;

  sample_buffer_writer_if bus_if ();

  sample_buffer_writer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural RAM pair: every clock, the selected half stores (addr, data).
  logic [11:0] ram0 [0:DEPTH_TB-1];
  logic [11:0] ram1 [0:DEPTH_TB-1];
  int          start_cnt  = 0;
  int          consec_cnt = 0;
  bit          prev_sr    = 1'b0;

  // Monitor: RAM writes, start_round pulse count, back-to-back pulse count.
  always @(posedge clk) begin
    if (bus_if.en[0] === 1'b1) ram0[bus_if.addr] <= bus_if.current_sample;
    if (bus_if.en[1] === 1'b1) ram1[bus_if.addr] <= bus_if.current_sample;
    if (bus_if.start_round === 1'b1) start_cnt <= start_cnt + 1;
    if (bus_if.start_round === 1'b1 && prev_sr) consec_cnt <= consec_cnt + 1;
    prev_sr <= (bus_if.start_round === 1'b1);
  end

  // Round-level reference model.
  logic [11:0] round_data [0:DEPTH_TB-1];
  int          fill_idx;
  bit          writing;
  bit          est_busy;
  logic [1:0]  exp_en;
  logic [11:0] exp_sample;
  int          exp_starts;

  int total_cnt = 0;
  int bad_cnt   = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_en"}, {30'd0, bus_if.en}, 32'h1);
    check_eq({tag, "_addr"}, {21'd0, bus_if.addr}, 32'h0);
    check_eq({tag, "_cs"}, {20'd0, bus_if.current_sample}, 32'h0);
    check_eq({tag, "_nw"}, {31'd0, bus_if.now_writing}, 32'h1);
    check_eq({tag, "_sr"}, {31'd0, bus_if.start_round}, 32'h0);
  endtask

  task automatic model_reset();
    fill_idx   = 0;
    writing    = 1'b1;
    est_busy   = 1'b0;
    exp_en     = 2'b01;
    exp_sample = 12'd0;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called #1 after the edge that should release the full half.
  task automatic expect_release(input bit took_tick, input logic [11:0] data);
    logic [1:0]  old_en;
    logic [1:0]  new_en;
    logic [11:0] v;
    int          mism;
    old_en = exp_en;
    new_en = (old_en == 2'b01) ? 2'b10 : 2'b01;
    check_eq("rel_sr", {31'd0, bus_if.start_round}, 32'h1);
    check_eq("rel_en", {30'd0, bus_if.en}, {30'd0, new_en});
    check_eq("rel_addr", {21'd0, bus_if.addr}, 32'h0);
    check_eq("rel_nw", {31'd0, bus_if.now_writing}, 32'h1);
    mism = 0;
    for (int i = 0; i < DEPTH_TB; i++) begin
      v = old_en[0] ? ram0[i] : ram1[i];
      if (v !== round_data[i]) mism++;
    end
    check_eq("rel_ram_image", mism, 32'h0);
    exp_en   = new_en;
    est_busy = 1'b1;
    writing  = 1'b1;
    fill_idx = 0;
    exp_starts++;
    if (took_tick) begin
      check_eq("rel_tick_cs", {20'd0, bus_if.current_sample}, {20'd0, data});
      round_data[0] = data;
      fill_idx      = 1;
      exp_sample    = data;
    end
    wait_cycles(1);
    check_eq("rel_sr_single", {31'd0, bus_if.start_round}, 32'h0);
    check_eq("rel_en_hold", {30'd0, bus_if.en}, {30'd0, new_en});
  endtask

  task automatic send_tick(input logic [11:0] data, input int gap);
    bus_if.sample_tick  = 1'b1;
    bus_if.current_data = data;
    @(posedge clk);
    #1;
    bus_if.sample_tick  = 1'b0;
    bus_if.current_data = $urandom_range(0, 4095);
    if (writing) begin
      check_eq("tick_addr", {21'd0, bus_if.addr}, fill_idx);
      check_eq("tick_cs", {20'd0, bus_if.current_sample}, {20'd0, data});
      round_data[fill_idx] = data;
      fill_idx++;
      exp_sample = data;
      if (fill_idx == DEPTH_TB) begin
        wait_cycles(1);
        if (!est_busy) begin
          expect_release(1'b0, 12'd0);
        end else begin
          check_eq("wait_sr", {31'd0, bus_if.start_round}, 32'h0);
          check_eq("wait_nw", {31'd0, bus_if.now_writing}, 32'h0);
          check_eq("wait_en", {30'd0, bus_if.en}, {30'd0, exp_en});
          check_eq("wait_addr", {21'd0, bus_if.addr}, DEPTH_TB - 1);
          writing = 1'b0;
        end
      end
    end else begin
      check_eq("drop_cs", {20'd0, bus_if.current_sample}, {20'd0, exp_sample});
      check_eq("drop_addr", {21'd0, bus_if.addr}, DEPTH_TB - 1);
      check_eq("drop_nw", {31'd0, bus_if.now_writing}, 32'h0);
    end
    wait_cycles(gap - 1);
  endtask

  // One-cycle f0_done, optionally with a coincident sample tick.
  task automatic f0_pulse(input bit with_tick, input logic [11:0] data);
    bus_if.f0_done = 1'b1;
    if (with_tick) begin
      bus_if.sample_tick  = 1'b1;
      bus_if.current_data = data;
    end
    @(posedge clk);
    #1;
    bus_if.f0_done     = 1'b0;
    bus_if.sample_tick = 1'b0;
    if (!writing) begin
      expect_release(with_tick, data);
    end else begin
      check_eq("f0_fill_sr", {31'd0, bus_if.start_round}, 32'h0);
      est_busy = 1'b0;
    end
    wait_cycles(1);
  endtask

  task automatic fill_ticks(input int n, input bit index_data, input int f0_after);
    logic [11:0] d;
    for (int i = 0; i < n; i++) begin
      d = index_data ? 12'(fill_idx) : 12'($urandom_range(0, 4095));
      send_tick(d, 2 + $urandom_range(0, 2));
      if (i == f0_after) f0_pulse(1'b0, 12'd0);
    end
  endtask

  int snap;

  initial begin
    rst                 = 1'b1;
    bus_if.f0_done      = 1'b0;
    bus_if.sample_tick  = 1'b0;
    bus_if.current_data = 12'd0;
    exp_starts          = 0;
    model_reset();
    wait_cycles(3);
    check_reset_outputs("rst");
    rst = 1'b0;

    // Idle with no ticks: nothing moves.
    wait_cycles(100);
    check_reset_outputs("idle");
    check_eq("idle_starts", start_cnt, 32'h0);

    // f0_done with no round outstanding is ignored.
    f0_pulse(1'b0, 12'd0);

    // Round 1: data = index, estimator idle, immediate release of buffer0.
    fill_ticks(DEPTH_TB, 1'b1, -1);
    check_eq("r1_en", {30'd0, bus_if.en}, 32'h2);

    // Round 2: no f0_done, so the writer parks in WAIT; extra ticks dropped.
    fill_ticks(DEPTH_TB, 1'b0, -1);
    fill_ticks(6, 1'b0, -1);

    // f0_done in WAIT releases buffer1 at once.
    f0_pulse(1'b0, 12'd0);
    check_eq("r2_en", {30'd0, bus_if.en}, 32'h1);

    // Round 3: estimator finishes mid-fill, so the full half swaps with no WAIT.
    fill_ticks(DEPTH_TB, 1'b0, 500);
    check_eq("r3_nw", {31'd0, bus_if.now_writing}, 32'h1);

    // Round 4: reset after 1000 ticks abandons the partial fill.
    fill_ticks(1000, 1'b0, -1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    check_reset_outputs("midrst");
    snap = start_cnt;
    fill_ticks(DEPTH_TB - 1, 1'b0, -1);
    check_eq("midrst_no_early_start", start_cnt, snap);
    fill_ticks(1, 1'b0, -1);
    check_eq("midrst_release", start_cnt, snap + 1);

    // Round 5: WAIT again, then f0_done with a coincident tick -> index 0.
    fill_ticks(DEPTH_TB, 1'b0, -1);
    f0_pulse(1'b1, 12'($urandom_range(0, 4095)));
    fill_ticks(10, 1'b0, -1);

    check_eq("start_count", start_cnt, exp_starts);
    check_eq("start_consecutive", consec_cnt, 32'h0);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt + 1);
    $fatal(1, "watchdog expired");
  end

endmodule
